// File: rtl/event_dispatcher_pkg.sv
// Shared types for the event dispatcher.
// State encoding, transfer kind and message field offsets.
package event_dispatcher_pkg;

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    typedef enum logic {
        XF_DISP = 1'b0,
        XF_RTN  = 1'b1
    } xfer_t;

    // Timestamp sits at the bottom of the message.
    localparam int MSG_TIME_LSB = 0;

    // The LP id field starts right above the timestamp.
    function automatic int msg_lp_lsb(input int time_wid);
        return time_wid;
    endfunction

endpackage

// File: rtl/event_dispatcher_if.sv
// Queue, core and monitor signals of the event dispatcher.
// master = dispatcher side, slave = queue/cores/monitor side.
interface event_dispatcher_if #(
    parameter int NUM_CORE = 4,
    parameter int TIME_WID = 16,
    parameter int MSG_WID  = 32
);
    localparam int IW = $clog2(NUM_CORE);
    localparam int CW = $clog2(NUM_CORE + 1);

    logic                        q_vld;
    logic [MSG_WID-1:0]          q_msg;
    logic                        q_deq;
    logic                        q_enq;
    logic [MSG_WID-1:0]          q_enq_msg;
    logic                        q_enq_rdy;
    logic [NUM_CORE-1:0]         core_req;
    logic [MSG_WID-1:0]          core_msg;
    logic [NUM_CORE-1:0]         core_done;
    logic [NUM_CORE*MSG_WID-1:0] core_rtn_msg;
    logic [NUM_CORE-1:0]         core_ack;
    logic                        mon_sent_vld;
    logic                        mon_rcv_vld;
    logic [IW-1:0]               mon_core_id;
    logic [MSG_WID-1:0]          mon_msg;
    logic [TIME_WID-1:0]         min_time;
    logic                        min_time_vld;
    logic [CW-1:0]               active_cnt;

    modport master (
        input  q_vld, q_msg, q_enq_rdy,
        input  core_done, core_rtn_msg,
        input  min_time, min_time_vld,
        output q_deq, q_enq, q_enq_msg,
        output core_req, core_msg, core_ack,
        output mon_sent_vld, mon_rcv_vld,
        output mon_core_id, mon_msg,
        output active_cnt
    );

    modport slave (
        output q_vld, q_msg, q_enq_rdy,
        output core_done, core_rtn_msg,
        output min_time, min_time_vld,
        input  q_deq, q_enq, q_enq_msg,
        input  core_req, core_msg, core_ack,
        input  mon_sent_vld, mon_rcv_vld,
        input  mon_core_id, mon_msg,
        input  active_cnt
    );

endinterface

// File: rtl/event_dispatcher_rr_arbiter.sv
// Round-robin arbiter for core returns.
// Search starts at i_ptr and wraps; N must be a power of two.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_gnt,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int IW = $clog2(N);

    logic [IW-1:0] w_cand;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        o_any  = 1'b0;
        o_idx  = i_ptr;
        w_cand = i_ptr;
        for (int i = 0; i < N; i++) begin
            w_cand = i_ptr + IW'(i);
            if (!o_any && i_req[w_cand]) begin
                o_any = 1'b1;
                o_idx = w_cand;
            end
        end
    end

    assign o_gnt = o_any ? (N'(1) << o_idx) : '0;

endmodule

// File: rtl/event_dispatcher.sv
// Event dispatcher: queue head -> idle core, core return -> queue.
// Optional optimism window gated by `EVT_WINDOW_EN.
module event_dispatcher
    import event_dispatcher_pkg::*;
#(
    parameter int NUM_CORE = 4,
    parameter int NUM_LP   = 8,
    parameter int TIME_WID = 16,
    parameter int MSG_WID  = 32,
    parameter int WINDOW   = 64
) (
    input  logic clk,
    input  logic reset,
    event_dispatcher_if.master bus
);
    localparam int IW = $clog2(NUM_CORE);
    localparam int CW = $clog2(NUM_CORE + 1);

    state_t              r_state;
    state_t              w_state_nxt;
    xfer_t               r_kind;
    logic [NUM_CORE-1:0] r_idle;
    logic [NUM_CORE-1:0] w_idle_nxt;
    logic [IW-1:0]       r_rr_ptr;
    logic [IW-1:0]       r_lat_id;
    logic [MSG_WID-1:0]  r_lat_msg;
    logic [CW-1:0]       r_active_cnt;
    logic [CW-1:0]       w_busy_cnt;

    logic [NUM_CORE-1:0] w_rtn_req;
    logic [NUM_CORE-1:0] w_rtn_gnt;
    logic [IW-1:0]       w_rtn_idx;
    logic                w_rtn_any;
    logic [MSG_WID-1:0]  w_rtn_msg;
    logic [IW-1:0]       w_idle_idx;
    logic                w_idle_any;
    logic                w_win_ok;
    logic                w_is_arb;
    logic                w_is_issue;
    logic                w_dispatch;
    logic [1:0]          w_param_unused;

    assign w_is_arb   = (r_state == ST_ARB);
    assign w_is_issue = (r_state == ST_ISSUE);

    // A done flag only counts from a busy core, and only
    // when the queue can take the returned event.
    assign w_rtn_req = bus.core_done & ~r_idle
                     & {NUM_CORE{bus.q_enq_rdy}};

    rr_arbiter #(
        .N (NUM_CORE)
    ) u_rr_arbiter (
        .i_req (w_rtn_req),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_rtn_gnt),
        .o_idx (w_rtn_idx),
        .o_any (w_rtn_any)
    );

    // Select the granted core's return slice.
    always_comb begin
        w_rtn_msg = '0;
        for (int i = 0; i < NUM_CORE; i++) begin
            if (w_rtn_gnt[i]) begin
                w_rtn_msg = w_rtn_msg
                          | bus.core_rtn_msg[i*MSG_WID +: MSG_WID];
            end
        end
    end

    // Lowest-index idle core.
    always_comb begin
        w_idle_any = 1'b0;
        w_idle_idx = '0;
        for (int i = NUM_CORE - 1; i >= 0; i--) begin
            if (r_idle[i]) begin
                w_idle_any = 1'b1;
                w_idle_idx = IW'(i);
            end
        end
    end

`ifdef EVT_WINDOW_EN
    logic [TIME_WID:0] w_win_lim;
    logic [TIME_WID:0] w_head_time;

    // One extra bit keeps min_time + WINDOW from wrapping.
    assign w_win_lim   = {1'b0, bus.min_time}
                       + (TIME_WID+1)'(WINDOW);
    assign w_head_time = {1'b0, bus.q_msg[MSG_TIME_LSB +: TIME_WID]};
    assign w_win_ok    = !bus.min_time_vld
                       || (w_head_time <= w_win_lim);
`else
    logic w_win_unused;

    assign w_win_ok     = 1'b1;
    assign w_win_unused = ^{bus.min_time, bus.min_time_vld};
`endif

    assign w_param_unused = {NUM_LP[0], WINDOW[0]};

    // Returns always beat dispatch in the same ARB cycle.
    assign w_dispatch = w_is_arb & bus.q_vld & w_idle_any
                      & w_win_ok & ~w_rtn_any;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state: ISSUE lasts exactly one cycle.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_ARB: begin
                if (w_rtn_any || w_dispatch) begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: w_state_nxt = ST_ARB;
            default:  w_state_nxt = ST_ARB;
        endcase
    end

    // Strobes: q_deq in ARB, one-hot pulses in ISSUE.
    always_comb begin
        bus.q_deq        = w_dispatch;
        bus.core_req     = '0;
        bus.core_ack     = '0;
        bus.q_enq        = 1'b0;
        bus.mon_sent_vld = 1'b0;
        bus.mon_rcv_vld  = 1'b0;
        if (w_is_issue) begin
            if (r_kind == XF_DISP) begin
                bus.core_req[r_lat_id] = 1'b1;
                bus.mon_sent_vld       = 1'b1;
            end else begin
                bus.core_ack[r_lat_id] = 1'b1;
                bus.q_enq              = 1'b1;
                bus.mon_rcv_vld        = 1'b1;
            end
        end
    end

    // Latched values only change on an ARB grant, so
    // the monitor sees them held until the next ISSUE.
    assign bus.core_msg    = r_lat_msg;
    assign bus.q_enq_msg   = r_lat_msg;
    assign bus.mon_msg     = r_lat_msg;
    assign bus.mon_core_id = r_lat_id;
    assign bus.active_cnt  = r_active_cnt;

    // Idle map after the current ISSUE completes.
    always_comb begin
        w_idle_nxt = r_idle;
        if (w_is_issue) begin
            w_idle_nxt[r_lat_id] = (r_kind == XF_RTN);
        end
    end

    // Busy count from the updated idle map.
    always_comb begin
        w_busy_cnt = CW'(NUM_CORE);
        for (int i = 0; i < NUM_CORE; i++) begin
            if (w_idle_nxt[i]) begin
                w_busy_cnt = w_busy_cnt - CW'(1);
            end
        end
    end

    // Idle map and busy count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idle       <= '1;
            r_active_cnt <= '0;
        end else begin
            r_idle       <= w_idle_nxt;
            r_active_cnt <= w_busy_cnt;
        end
    end

    // Capture the granted transaction in ARB.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lat_msg <= '0;
            r_lat_id  <= '0;
            r_kind    <= XF_DISP;
            r_rr_ptr  <= '0;
        end else if (w_is_arb) begin
            if (w_rtn_any) begin
                r_lat_msg <= w_rtn_msg;
                r_lat_id  <= w_rtn_idx;
                r_kind    <= XF_RTN;
                r_rr_ptr  <= w_rtn_idx + IW'(1);
            end else if (w_dispatch) begin
                r_lat_msg <= bus.q_msg;
                r_lat_id  <= w_idle_idx;
                r_kind    <= XF_DISP;
            end
        end
    end

endmodule
